wm_embed_ctrl: RTL

Sequencing controller for the watermark embedder. On `start` it walks a programmable band of image rows and performs read–modify–write on every pixel in the band. It reads the image pixel and the tiled 2-bit watermark symbol, scrambles the symbol with the key, replaces the pixel's two LSBs, and writes the pixel back. It sits between the top-level handshake (`start`/`Ready`/`Busy`) and the image and watermark memories, and owns all of their address and read/write strobes.

---
 rtl/wm_embed_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wm_embed_ctrl.sv
// rtl/wm_embed_ctrl.sv - watermark embedder read-modify-write sequencer over a band of image rows
// Optional macro WM_LFSR_EN: per-pixel key stream from an 8-bit LFSR instead of fixed key bits.

module wm_embed_ctrl #(
    parameter int IM_ROWS = 256,
    parameter int IM_COLS = 256,
    parameter int WM_ROWS = 64,
    parameter int WM_COLS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] key,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] IM_data_in,
    input  logic [1:0] WM_data_in,
    output logic [7:0] Row_IM_addr,
    output logic [7:0] Col_IM_addr,
    output logic [7:0] Row_WM_addr,
    output logic [7:0] Col_WM_addr,
    output logic       IM_RD_WRn,
    output logic       WM_RD_WRn,
    output logic [7:0] IM_data_out,
    output logic       Ready,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    localparam logic [8:0] LAST_ROW    = 9'(IM_ROWS - 1);
    localparam logic [8:0] LAST_COL    = 9'(IM_COLS - 1);
    localparam logic [7:0] WM_ROW_MASK = 8'(WM_ROWS - 1);
    localparam logic [7:0] WM_COL_MASK = 8'(WM_COLS - 1);

    state_t     state, next_state;
    logic [8:0] row, col, band_end;
    logic [8:0] a2_clamp, row_step, col_step;
    logic       band_ok, col_wrap, last_pixel, accept;
    logic [1:0] kbits;

    // 9-bit counters let the band end at row 255 without wrapping back to 0
    always_comb begin
        a2_clamp   = ({1'b0, a2} > LAST_ROW) ? LAST_ROW : {1'b0, a2};
        band_ok    = ({1'b0, a1} <= a2_clamp);
        accept     = (state == IDLE) && start && band_ok;
        col_wrap   = (col == LAST_COL);
        last_pixel = col_wrap && (row == band_end);
        col_step   = col_wrap ? 9'd0 : col + 9'd1;
        row_step   = col_wrap ? row + 9'd1 : row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RD;
            RD:      next_state = CALC;
            CALC:    next_state = WR;
            WR:      next_state = last_pixel ? IDLE : RD;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from the async-reset state so a reset in WR drops the write strobe at once
    always_comb begin
        IM_RD_WRn = (state != WR);
        WM_RD_WRn = 1'b1;
        Ready     = (state == IDLE);
        Busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= 9'd0;
            col         <= 9'd0;
            band_end    <= 9'd0;
            Row_IM_addr <= 8'd0;
            Col_IM_addr <= 8'd0;
            Row_WM_addr <= 8'd0;
            Col_WM_addr <= 8'd0;
            IM_data_out <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        band_end <= a2_clamp;
                        if (band_ok) begin
                            row         <= {1'b0, a1};
                            col         <= 9'd0;
                            Row_IM_addr <= a1;
                            Col_IM_addr <= 8'd0;
                            Row_WM_addr <= a1 & WM_ROW_MASK;
                            Col_WM_addr <= 8'd0;
                        end
                    end
                end
                CALC: begin
                    IM_data_out <= (IM_data_in & 8'hFC) | {6'd0, WM_data_in ^ kbits};
                end
                WR: begin
                    row <= row_step;
                    col <= col_step;
                    // Addresses freeze on the final pixel so IDLE keeps the last ones
                    if (!last_pixel) begin
                        Row_IM_addr <= row_step[7:0];
                        Col_IM_addr <= col_step[7:0];
                        Row_WM_addr <= row_step[7:0] & WM_ROW_MASK;
                        Col_WM_addr <= col_step[7:0] & WM_COL_MASK;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WM_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'h01;
        end else if (accept) begin
            lfsr <= (key == 8'd0) ? 8'h01 : key;
        end else if (state == WR) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign kbits = lfsr[1:0];
`else
    logic [1:0] key_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_bits <= 2'd0;
        end else if ((state == IDLE) && start) begin
            key_bits <= key[1:0];
        end
    end

    assign kbits = key_bits;
`endif

endmodule
